axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Parametrised AXI read-channel front end that merges NUM_MST independent read requesters onto one AXI AR/R channel pair.
- Typical requesters: icache refill, dcache refill and the uncached data path.
- Successor to the fixed two-cache read path in the SRAM-to-AXI bridge. Adds configurable master count and line length, round-robin fairness, one outstanding burst per master with ID-based response routing, and beat-count and error checking.
- Sits between the cache/uncached request ports and the top-level AXI read pins.

Parameters:
- NUM_MST, 3, number of requesters; requester i drives arid = i. Legal range 2..16.
- LINE_WORDS, 4, words per cache-line burst (power of 2, 2..16).
- ID_W, 4, AXI ID width; must satisfy 2**ID_W >= NUM_MST.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous reset, active-high
- rd_req  in  NUM_MST  per-requester read request
- rd_type  in  3*NUM_MST  per-requester type: 000 byte, 001 half, 010 word, 100 line
- rd_addr  in  32*NUM_MST  per-requester physical address
- rd_rdy  out  NUM_MST  grant; a request is accepted on rd_req[i] & rd_rdy[i]
- ret_valid  out  NUM_MST  returned data valid for requester i
- ret_last  out  NUM_MST  last beat for requester i
- ret_data  out  32  returned data, shared by all requesters
- arid  out  ID_W  AXI read address ID
- araddr  out  32  AXI read address
- arlen  out  8  AXI burst length minus one
- arsize  out  3  AXI bytes per beat (encoded)
- arburst  out  2  AXI burst type
- arlock  out  2  AXI lock
- arcache  out  4  AXI cache attributes
- arprot  out  3  AXI protection
- arvalid  out  1  AXI read address valid
- arready  in  1  AXI read address ready
- rid  in  ID_W  AXI read response ID
- rdata  in  32  AXI read data
- rresp  in  2  AXI read response
- rlast  in  1  AXI last beat
- rvalid  in  1  AXI read data valid
- rready  out  1  always 1
- err  out  1  sticky protocol/response error flag

Behaviour:
- Reset (async): arvalid=0, ar* payload=0, outstanding[]=0, beat counters=0, RR pointer=0, err=0, rd_rdy=0, ret_valid=0, ret_last=0. rready=1 at all times.
- AR slot is free when ~arvalid | arready, so a new request can be loaded in the same cycle as the AR handshake.
- Eligible requester: rd_req[i] & ~outstanding[i].
- Round-robin grant: rd_rdy[i]=1 (combinational) only for the first eligible requester at or after the RR pointer, and only while the slot is free. At most one rd_rdy bit is high.
- On acceptance, next cycle:
  - arvalid=1, arid=i, set outstanding[i], RR pointer = i+1 mod NUM_MST.
  - Line request: arlen=LINE_WORDS-1, arsize=2, araddr with the low log2(LINE_WORDS*4) bits cleared.
  - Single request: arlen=0, arsize=rd_type[1:0], araddr as given.
- AR payload holds stable while arvalid & ~arready.
- Constant AR fields: arburst=01, arlock=0, arcache=0, arprot=0.
- R routing, combinational from R inputs (0-cycle latency):
  - ret_data=rdata.
  - ret_valid[rid]=rvalid & outstanding[rid].
  - ret_last[rid]=rvalid & rlast & outstanding[rid].
- Per-master beat counter increments on each routed beat. On rlast: clear outstanding[rid] and zero the counter.
- err sets (sticky until reset) on any of:
  - rresp != 0;
  - rvalid with ~outstanding[rid] (that beat is dropped, no ret_valid);
  - rlast on a beat count != expected (LINE_WORDS-1 or 0 per latched type);
  - a non-last beat when the count already equals the expected count.
- Simultaneous last beat for master i and a new request from i in the same cycle: not granted that cycle; granted the next cycle.
- Reset mid-burst: all state cleared. Trailing beats are dropped and set err after reset deasserts.

Decomposition:
- Shared package holds: RD_TYPE_BYTE/HALF/WORD/LINE encodings, AXI_BURST_INCR, AXI_RESP_OKAY, and the function clog2.
- One sub-module, rr_arbiter (parametrised NUM_MST one-hot round-robin grant with pointer input), is natural; everything else stays inline.

Test Plan:
- Single line read: requester 1 (dcache) requests line at 0x1C00_0014 → arid=1, araddr=0x1C00_0010, arlen=3, arsize=2. Four rdata beats → ret_valid[1] x4, ret_last[1] on the 4th beat only, err=0.
- Round robin: all three requesters hold rd_req continuously, slave always arready → grants in order 0,1,2, and 0 is not re-granted until its burst completes.
- Interleaved responses: lines for IDs 0 and 2 outstanding, R beats interleave 0,2,2,0,… → each beat is routed only to its ID, and both ret_last pulses occur.
- Uncached half-word read to 0xBFAF_8002 → arlen=0, arsize=1, araddr unchanged; a single beat gives ret_valid=ret_last=1.
- Backpressure: arready=0 for 5 cycles → araddr/arid stable and rd_rdy all 0. When arready rises while another requester is pending, arvalid stays high with the new payload on the next cycle.
- Errors: rresp=2 on a beat → err=1 and stays 1. A beat with rid=3 while nothing is outstanding → dropped, err=1. Early rlast on beat 2 of a line → err=1 and outstanding cleared.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared encodings and helpers for the AXI read-channel arbiter.
package axi_rd_arbiter_pkg;

  localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
  localparam logic [2:0] RD_TYPE_HALF = 3'b001;
  localparam logic [2:0] RD_TYPE_WORD = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE = 3'b100;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Requester ports plus AXI AR/R channel bundle. The master modport is the
// arbiter's view; the slave modport is the requesters and AXI memory together.
interface axi_rd_arbiter_if #(
  parameter int NUM_MST = 3,
  parameter int ID_W    = 4
);
  logic [NUM_MST-1:0]    rd_req;
  logic [3*NUM_MST-1:0]  rd_type;
  logic [32*NUM_MST-1:0] rd_addr;
  logic [NUM_MST-1:0]    rd_rdy;
  logic [NUM_MST-1:0]    ret_valid;
  logic [NUM_MST-1:0]    ret_last;
  logic [31:0]           ret_data;

  logic [ID_W-1:0]       arid;
  logic [31:0]           araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [1:0]            arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_W-1:0]       rid;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;
  logic                  err;

  modport master (
    input  rd_req, rd_type, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
    output rd_rdy, ret_valid, ret_last, ret_data,
           arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
           rready, err
  );

  modport slave (
    output rd_req, rd_type, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
    input  rd_rdy, ret_valid, ret_last, ret_data,
           arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
           rready, err
  );

endinterface

// File: rtl/axi_rd_arbiter_rr_arbiter.sv
// One-hot round-robin grant: lowest request at or above i_ptr, else wrap to
// the lowest request overall.
module axi_rd_arbiter_rr_arbiter #(
  parameter int NUM_MST = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_MST-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_MST-1:0] o_gnt
);

  logic [NUM_MST-1:0] w_mask;
  logic [NUM_MST-1:0] w_req_hi;

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_MST; i++) w_mask[i] = (PTR_W'(i) >= i_ptr);
  end

  assign w_req_hi = i_req & w_mask;

  // x & -x isolates the lowest set bit.
  assign o_gnt = (|w_req_hi) ? (w_req_hi & (~w_req_hi + NUM_MST'(1)))
                             : (i_req    & (~i_req    + NUM_MST'(1)));

endmodule

// File: rtl/axi_rd_arbiter.sv
// Merges NUM_MST read requesters onto one AXI AR/R pair: round-robin AR
// issue, one outstanding burst per requester, ID-routed responses.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int NUM_MST    = 3,
  parameter int LINE_WORDS = 4,
  parameter int ID_W       = 4
) (
  input logic             aclk,
  input logic             areset,
  axi_rd_arbiter_if.master bus
);

  localparam int              PTR_W     = clog2(NUM_MST);
  localparam int              CNT_W     = clog2(LINE_WORDS) + 1;
  localparam logic [31:0]     LINE_MASK = ~32'(LINE_WORDS * 4 - 1);
  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(LINE_WORDS - 1);

  logic               r_arvalid;
  logic [ID_W-1:0]    r_arid;
  logic [31:0]        r_araddr;
  logic [7:0]         r_arlen;
  logic [2:0]         r_arsize;
  logic [PTR_W-1:0]   r_ptr;
  logic [NUM_MST-1:0] r_outstanding;
  logic [NUM_MST-1:0] r_is_line;
  logic [CNT_W-1:0]   r_beat [NUM_MST];
  logic               r_err;

  logic               w_slot_free;
  logic               w_accept;
  logic [NUM_MST-1:0] w_eligible;
  logic [NUM_MST-1:0] w_gnt;
  logic [NUM_MST-1:0] w_rdy;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [2:0]         w_sel_type;
  logic [31:0]        w_sel_addr;
  logic               w_sel_line;
  logic [NUM_MST-1:0] w_rid_hit;
  logic [NUM_MST-1:0] w_route;
  logic               w_beat_err;
  logic               w_err_set;

  assign w_slot_free = ~r_arvalid | bus.arready;
  assign w_eligible  = bus.rd_req & ~r_outstanding;

  axi_rd_arbiter_rr_arbiter #(
    .NUM_MST (NUM_MST),
    .PTR_W   (PTR_W)
  ) u_rr (
    .i_req (w_eligible),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  assign w_rdy    = (w_slot_free & ~areset) ? w_gnt : '0;
  assign w_accept = |w_rdy;

  always_comb begin
    w_gnt_idx  = '0;
    w_sel_type = '0;
    w_sel_addr = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (w_gnt[i]) begin
        w_gnt_idx  = PTR_W'(i);
        w_sel_type = bus.rd_type[3*i +: 3];
        w_sel_addr = bus.rd_addr[32*i +: 32];
      end
    end
  end

  assign w_sel_line = (w_sel_type == RD_TYPE_LINE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_arvalid <= 1'b0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_ptr     <= '0;
    end else if (w_accept) begin
      r_arvalid <= 1'b1;
      r_arid    <= ID_W'(w_gnt_idx);
      r_araddr  <= w_sel_line ? (w_sel_addr & LINE_MASK) : w_sel_addr;
      r_arlen   <= w_sel_line ? 8'(LINE_WORDS - 1) : 8'd0;
      r_arsize  <= w_sel_line ? 3'd2 : {1'b0, w_sel_type[1:0]};
      r_ptr     <= (w_gnt_idx == PTR_W'(NUM_MST - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
    end else if (bus.arready) begin
      r_arvalid <= 1'b0;
    end
  end

  always_comb begin
    w_rid_hit = '0;
    for (int i = 0; i < NUM_MST; i++) w_rid_hit[i] = bus.rvalid & (bus.rid == ID_W'(i));
  end

  assign w_route = w_rid_hit & r_outstanding;

  // A beat is out of order when rlast disagrees with "count reached expected".
  always_comb begin
    w_beat_err = 1'b0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (w_route[i] && (bus.rlast != (r_beat[i] == (r_is_line[i] ? LINE_LAST : '0))))
        w_beat_err = 1'b1;
    end
  end

  assign w_err_set = w_beat_err
                   | (bus.rvalid & (bus.rresp != AXI_RESP_OKAY))
                   | (bus.rvalid & ~(|w_route));

  // NOTE: the per-requester counter array is tiny control state, so it is
  // reset explicitly like any other register rather than left as memory.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_outstanding <= '0;
      r_is_line     <= '0;
      for (int i = 0; i < NUM_MST; i++) r_beat[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MST; i++) begin
        if (w_rdy[i]) begin
          r_outstanding[i] <= 1'b1;
          r_is_line[i]     <= w_sel_line;
        end
        if (w_route[i]) begin
          if (bus.rlast) begin
            r_outstanding[i] <= 1'b0;
            r_beat[i]        <= '0;
          end else begin
            r_beat[i] <= r_beat[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_err <= 1'b0;
    else        r_err <= r_err | w_err_set;
  end

  assign bus.rd_rdy    = w_rdy;
  assign bus.ret_valid = w_route;
  assign bus.ret_last  = w_route & {NUM_MST{bus.rlast}};
  assign bus.ret_data  = bus.rdata;
  assign bus.arid      = r_arid;
  assign bus.araddr    = r_araddr;
  assign bus.arlen     = r_arlen;
  assign bus.arsize    = r_arsize;
  assign bus.arburst   = AXI_BURST_INCR;
  assign bus.arlock    = 2'b00;
  assign bus.arcache   = 4'b0000;
  assign bus.arprot    = 3'b000;
  assign bus.arvalid   = r_arvalid;
  assign bus.rready    = 1'b1;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  localparam int N   = 3;
  localparam int LW  = 4;
  localparam int IDW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  axi_rd_arbiter_if #(.NUM_MST(N), .ID_W(IDW)) u_if ();

  axi_rd_arbiter #(.NUM_MST(N), .LINE_WORDS(LW), .ID_W(IDW)) u_dut (
    .aclk   (clk),
    .areset (rst),
    .bus    (u_if)
  );

  typedef struct {
    int          mst;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;
    logic [2:0]  exp_size;
  } vec_t;

  vec_t vecs [5];

  // Reference model state for the randomized run.
  bit              m_out [N];
  int              m_ptr;
  bit              m_arvalid;
  logic [IDW-1:0]  m_arid;
  logic [31:0]     m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  int              slv_rem [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    u_if.rd_req  = '0;
    u_if.rd_type = '0;
    u_if.rd_addr = '0;
    u_if.arready = 1'b0;
    u_if.rvalid  = 1'b0;
    u_if.rid     = '0;
    u_if.rdata   = '0;
    u_if.rresp   = '0;
    u_if.rlast   = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic set_req(input int m, input logic [2:0] t, input logic [31:0] a);
    u_if.rd_req[m]         = 1'b1;
    u_if.rd_type[3*m +: 3] = t;
    u_if.rd_addr[32*m +: 32] = a;
  endtask

  // Request, accept, and complete the AR handshake for one requester from idle.
  task automatic issue(input int m, input logic [2:0] t, input logic [31:0] a);
    u_if.rd_req = '0;
    set_req(m, t, a);
    tick();
    u_if.rd_req  = '0;
    u_if.arready = 1'b1;
    tick();
    u_if.arready = 1'b0;
  endtask

  task automatic beat(input int id, input bit last, input logic [1:0] resp,
                      input bit exp_routed, input string tag);
    logic [N-1:0] ev;
    logic [31:0]  d;
    d           = $urandom;
    u_if.rvalid = 1'b1;
    u_if.rid    = IDW'(id);
    u_if.rlast  = last;
    u_if.rresp  = resp;
    u_if.rdata  = d;
    #1;
    ev = '0;
    if (exp_routed) ev[id] = 1'b1;
    check({tag, " ret_valid"}, u_if.ret_valid, ev);
    check({tag, " ret_last"},  u_if.ret_last,  ev & {N{last}});
    check({tag, " ret_data"},  u_if.ret_data,  d);
    tick();
    u_if.rvalid = 1'b0;
    u_if.rlast  = 1'b0;
    u_if.rresp  = '0;
  endtask

  function automatic logic [2:0] pick_type(input int k);
    case (k)
      0:       return RD_TYPE_BYTE;
      1:       return RD_TYPE_HALF;
      2:       return RD_TYPE_WORD;
      default: return RD_TYPE_LINE;
    endcase
  endfunction

  task automatic rand_cycle(input bit allow_req);
    int           act_ids [$];
    int           g;
    int           pick;
    bit           slot_free;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_ret;
    u_if.rd_req = allow_req ? N'($urandom) : '0;
    for (int m = 0; m < N; m++) begin
      u_if.rd_type[3*m +: 3]   = pick_type($urandom_range(0, 3));
      u_if.rd_addr[32*m +: 32] = $urandom;
    end
    u_if.arready = allow_req ? ($urandom_range(0, 3) != 0) : 1'b1;
    pick = -1;
    for (int m = 0; m < N; m++) if (slv_rem[m] > 0) act_ids.push_back(m);
    if (act_ids.size() > 0 && $urandom_range(0, 2) != 0) begin
      pick        = act_ids[$urandom_range(0, act_ids.size() - 1)];
      u_if.rvalid = 1'b1;
      u_if.rid    = IDW'(pick);
      u_if.rlast  = (slv_rem[pick] == 1);
      u_if.rdata  = $urandom;
      u_if.rresp  = '0;
    end else begin
      u_if.rvalid = 1'b0;
      u_if.rlast  = 1'b0;
    end
    #1;
    // Grant rule: first requester with a request and no burst in flight,
    // scanning upward from the pointer, only while the AR slot is free.
    slot_free = !m_arvalid || u_if.arready;
    g = -1;
    if (slot_free) begin
      for (int k = 0; k < N; k++) begin
        int m;
        m = (m_ptr + k) % N;
        if (g < 0 && u_if.rd_req[m] && !m_out[m]) g = m;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_ret = '0;
    if (pick >= 0) exp_ret[pick] = 1'b1;
    check("rand rd_rdy", u_if.rd_rdy, exp_rdy);
    check("rand arvalid", u_if.arvalid, m_arvalid);
    if (m_arvalid)
      check("rand ar payload", {u_if.arid, u_if.araddr, u_if.arlen, u_if.arsize},
            {m_arid, m_araddr, m_arlen, m_arsize});
    check("rand ret_valid", u_if.ret_valid, exp_ret);
    check("rand ret_last", u_if.ret_last, exp_ret & {N{u_if.rlast}});
    check("rand err", u_if.err, 1'b0);
    if (m_arvalid && u_if.arready) slv_rem[int'(m_arid)] = int'(m_arlen) + 1;
    if (pick >= 0) begin
      slv_rem[pick]--;
      if (u_if.rlast) m_out[pick] = 1'b0;
    end
    if (g >= 0) begin
      logic [2:0]  t;
      logic [31:0] a;
      bit          ln;
      t  = u_if.rd_type[3*g +: 3];
      a  = u_if.rd_addr[32*g +: 32];
      ln = (t == RD_TYPE_LINE);
      m_arvalid = 1'b1;
      m_arid    = IDW'(g);
      m_araddr  = ln ? (a & ~32'(LW * 4 - 1)) : a;
      m_arlen   = ln ? 8'(LW - 1) : 8'd0;
      m_arsize  = ln ? 3'd2 : {1'b0, t[1:0]};
      m_out[g]  = 1'b1;
      m_ptr     = (g + 1) % N;
    end else if (u_if.arready) begin
      m_arvalid = 1'b0;
    end
    tick();
  endtask

  initial begin
    vecs[0] = '{1, RD_TYPE_LINE, 32'h1C00_0014, 32'h1C00_0010, 8'd3, 3'd2};
    vecs[1] = '{2, RD_TYPE_HALF, 32'hBFAF_8002, 32'hBFAF_8002, 8'd0, 3'd1};
    vecs[2] = '{0, RD_TYPE_BYTE, 32'h0000_0003, 32'h0000_0003, 8'd0, 3'd0};
    vecs[3] = '{0, RD_TYPE_WORD, 32'h8000_0FFC, 32'h8000_0FFC, 8'd0, 3'd2};
    vecs[4] = '{2, RD_TYPE_LINE, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 8'd3, 3'd2};

    // Reset state, with requests and a stray beat present during reset.
    idle();
    rst = 1'b1;
    u_if.rd_req = '1;
    u_if.rvalid = 1'b1;
    u_if.rlast  = 1'b1;
    @(posedge clk);
    #1;
    check("reset arvalid", u_if.arvalid, 1'b0);
    check("reset ar payload", {u_if.arid, u_if.araddr, u_if.arlen, u_if.arsize}, '0);
    check("reset rd_rdy", u_if.rd_rdy, '0);
    check("reset ret_valid", u_if.ret_valid, '0);
    check("reset ret_last", u_if.ret_last, '0);
    check("reset err", u_if.err, 1'b0);
    check("rready", u_if.rready, 1'b1);
    check("ar const fields", {u_if.arburst, u_if.arlock, u_if.arcache, u_if.arprot},
          {2'b01, 2'b00, 4'b0000, 3'b000});
    idle();
    rst = 1'b0;
    tick();
    check("post-reset err", u_if.err, 1'b0);

    // Table: single requester, AR encoding and full response for each.
    foreach (vecs[v]) begin
      u_if.rd_req = '0;
      set_req(vecs[v].mst, vecs[v].typ, vecs[v].addr);
      #1;
      check($sformatf("vec%0d rd_rdy", v), u_if.rd_rdy, N'(1) << vecs[v].mst);
      tick();
      u_if.rd_req = '0;
      check($sformatf("vec%0d arvalid", v), u_if.arvalid, 1'b1);
      check($sformatf("vec%0d arid", v), u_if.arid, IDW'(vecs[v].mst));
      check($sformatf("vec%0d araddr", v), u_if.araddr, vecs[v].exp_addr);
      check($sformatf("vec%0d arlen", v), u_if.arlen, vecs[v].exp_len);
      check($sformatf("vec%0d arsize", v), u_if.arsize, vecs[v].exp_size);
      u_if.arready = 1'b1;
      tick();
      u_if.arready = 1'b0;
      check($sformatf("vec%0d arvalid drop", v), u_if.arvalid, 1'b0);
      for (int b = 0; b <= int'(vecs[v].exp_len); b++)
        beat(vecs[v].mst, b == int'(vecs[v].exp_len), 2'b00, 1'b1, $sformatf("vec%0d b%0d", v, b));
      check($sformatf("vec%0d err", v), u_if.err, 1'b0);
    end

    // Round robin with all three holding requests; last-beat/regrant corner.
    do_reset();
    set_req(0, RD_TYPE_WORD, 32'h0);
    set_req(1, RD_TYPE_WORD, 32'h4);
    set_req(2, RD_TYPE_WORD, 32'h8);
    u_if.arready = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("rr grant %0d", k), u_if.rd_rdy, N'(1) << k);
      tick();
      check($sformatf("rr arid %0d", k), u_if.arid, IDW'(k));
    end
    check("rr all busy", u_if.rd_rdy, '0);
    tick();
    check("rr arvalid idle", u_if.arvalid, 1'b0);
    u_if.rvalid = 1'b1;
    u_if.rid    = '0;
    u_if.rlast  = 1'b1;
    #1;
    check("rr no grant on last beat", u_if.rd_rdy, '0);
    check("rr last beat routed", u_if.ret_last, 3'b001);
    tick();
    u_if.rvalid = 1'b0;
    u_if.rlast  = 1'b0;
    #1;
    check("rr regrant after last", u_if.rd_rdy, 3'b001);
    tick();
    u_if.rd_req = '0;
    check("rr regrant arid", {u_if.arvalid, u_if.arid}, {1'b1, IDW'(0)});
    tick();
    u_if.arready = 1'b0;
    beat(1, 1'b1, 2'b00, 1'b1, "rr drain1");
    beat(2, 1'b1, 2'b00, 1'b1, "rr drain2");
    beat(0, 1'b1, 2'b00, 1'b1, "rr drain0");
    check("rr err", u_if.err, 1'b0);

    // Interleaved line responses for IDs 0 and 2.
    do_reset();
    set_req(0, RD_TYPE_LINE, 32'h0000_1000);
    set_req(2, RD_TYPE_LINE, 32'h0000_2008);
    u_if.arready = 1'b1;
    #1;
    check("il grant0", u_if.rd_rdy, 3'b001);
    tick();
    check("il ar0", {u_if.arid, u_if.araddr}, {IDW'(0), 32'h0000_1000});
    check("il grant2", u_if.rd_rdy, 3'b100);
    tick();
    u_if.rd_req = '0;
    check("il ar2", {u_if.arid, u_if.araddr}, {IDW'(2), 32'h0000_2000});
    tick();
    u_if.arready = 1'b0;
    begin
      int seq [8] = '{0, 2, 2, 0, 0, 2, 2, 0};
      int cnt [N] = '{0, 0, 0};
      foreach (seq[s]) begin
        beat(seq[s], cnt[seq[s]] == LW - 1, 2'b00, 1'b1, $sformatf("il beat%0d", s));
        cnt[seq[s]]++;
      end
    end
    check("il err", u_if.err, 1'b0);

    // AR backpressure with a second requester waiting.
    do_reset();
    set_req(1, RD_TYPE_WORD, 32'h0000_0100);
    #1;
    check("bp grant1", u_if.rd_rdy, 3'b010);
    tick();
    set_req(2, RD_TYPE_WORD, 32'h0000_0200);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp stall%0d ar", c), {u_if.arvalid, u_if.arid, u_if.araddr},
            {1'b1, IDW'(1), 32'h0000_0100});
      check($sformatf("bp stall%0d rd_rdy", c), u_if.rd_rdy, '0);
      tick();
    end
    u_if.arready = 1'b1;
    #1;
    check("bp grant2 on ready", u_if.rd_rdy, 3'b100);
    tick();
    u_if.rd_req = '0;
    check("bp back-to-back ar", {u_if.arvalid, u_if.arid, u_if.araddr},
          {1'b1, IDW'(2), 32'h0000_0200});
    tick();
    u_if.arready = 1'b0;
    check("bp arvalid drop", u_if.arvalid, 1'b0);
    beat(1, 1'b1, 2'b00, 1'b1, "bp drain1");
    beat(2, 1'b1, 2'b00, 1'b1, "bp drain2");
    check("bp err", u_if.err, 1'b0);

    // Randomized traffic against the model, then a drain phase.
    do_reset();
    m_ptr = 0;
    m_arvalid = 1'b0;
    m_arid = '0;
    m_araddr = '0;
    m_arlen = '0;
    m_arsize = '0;
    for (int m = 0; m < N; m++) begin
      m_out[m]   = 1'b0;
      slv_rem[m] = 0;
    end
    repeat (1500) rand_cycle(1'b1);
    repeat (60) rand_cycle(1'b0);
    idle();

    // Error: beat for an ID with nothing outstanding.
    do_reset();
    beat(3, 1'b1, 2'b00, 1'b0, "stray rid3");
    check("stray err", u_if.err, 1'b1);

    // Error: non-OKAY response, sticky.
    do_reset();
    issue(0, RD_TYPE_WORD, 32'h40);
    beat(0, 1'b1, 2'b10, 1'b1, "slverr");
    check("slverr err", u_if.err, 1'b1);
    repeat (3) tick();
    check("slverr sticky", u_if.err, 1'b1);

    // Error: early rlast on beat 2 of a line; outstanding must clear.
    do_reset();
    issue(0, RD_TYPE_LINE, 32'h80);
    beat(0, 1'b0, 2'b00, 1'b1, "early b0");
    check("early no err yet", u_if.err, 1'b0);
    beat(0, 1'b1, 2'b00, 1'b1, "early b1");
    check("early err", u_if.err, 1'b1);
    set_req(0, RD_TYPE_WORD, 32'h0);
    #1;
    check("early outstanding cleared", u_if.rd_rdy, 3'b001);
    tick();
    idle();

    // Error: missing rlast on a single-beat read.
    do_reset();
    issue(1, RD_TYPE_WORD, 32'h10);
    beat(1, 1'b0, 2'b00, 1'b1, "overrun");
    check("overrun err", u_if.err, 1'b1);

    // Reset mid-burst: trailing beat dropped and flagged.
    do_reset();
    issue(2, RD_TYPE_LINE, 32'h100);
    beat(2, 1'b0, 2'b00, 1'b1, "midrst b0");
    do_reset();
    check("midrst err cleared", u_if.err, 1'b0);
    beat(2, 1'b0, 2'b00, 1'b0, "midrst trailing");
    check("midrst err", u_if.err, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
